// File: rtl/aes_pkg.sv
// aes_pkg: shared state enum, block geometry and word-slice helpers
// for the AES stream controller.
package aes_pkg;

   localparam int AES_BLK_W  = 128;
   localparam int AES_WORD_W = 32;
   localparam int AES_WORDS  = 4;

   typedef enum logic [2:0] {
      ST_KEY,
      ST_TEXT,
      ST_LOAD,
      ST_WAIT,
      ST_DRAIN
   } aes_state_t;

   typedef logic [1:0] aes_idx_t;

   // word 0 is the most significant slice of a block
   function automatic int aes_lsb(aes_idx_t idx);
      return (AES_WORDS - 1 - int'(idx)) * AES_WORD_W;
   endfunction

   function automatic logic [AES_WORD_W-1:0] aes_get_word(
      logic [AES_BLK_W-1:0] blk,
      aes_idx_t             idx
   );
      return blk[aes_lsb(idx) +: AES_WORD_W];
   endfunction

endpackage

// File: rtl/aes_word_unpack.sv
// aes_word_unpack: 4x32 ciphertext buffer streamed out word by word
// with valid/ready back-pressure and a last-word marker.
module aes_word_unpack
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [AES_BLK_W-1:0]  blk,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [AES_WORD_W-1:0] m_data,
   output logic                  m_last,
   output logic                  drained
);

   logic [AES_BLK_W-1:0] obuf;
   aes_idx_t             idx;
   logic                 hs;

   assign hs      = m_valid & m_ready;
   assign m_last  = m_valid & (idx == 2'd3);
   assign drained = hs & (idx == 2'd3);
   assign m_data  = aes_get_word(obuf, idx);

   always_ff @(posedge clk) begin
      if (!reset) begin
         obuf    <= '0;
         idx     <= '0;
         m_valid <= 1'b0;
      end else if (load) begin
         obuf    <= blk;
         idx     <= '0;
         m_valid <= 1'b1;
      end else if (hs) begin
         idx <= idx + 2'd1;
         if (idx == 2'd3)
            m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: word-stream front/back-end for aes_cipher_top.
// Optional key reuse across blocks: define AES_KEY_CACHE_EN.
module aes_stream_ctrl
   import aes_pkg::*;
#(
   parameter int CAPTURE_DLY = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [AES_WORD_W-1:0] s_data,
   input  logic                  s_new_key,
   output logic                  core_ld,
   output logic [AES_BLK_W-1:0]  core_key,
   output logic [AES_BLK_W-1:0]  core_text_in,
   input  logic                  core_done,
   input  logic [AES_BLK_W-1:0]  core_text_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [AES_WORD_W-1:0] m_data,
   output logic                  m_last,
   output logic                  err_timeout
);

   localparam int TW   = $clog2(TIMEOUT_CYC + 2) + 1;
   localparam int TLIM = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic [2:0] CDLY = 3'(CAPTURE_DLY);

   aes_state_t    state, state_n;
   aes_idx_t      wcnt;
   logic [TW-1:0] tcnt;
   logic [2:0]    ccnt;
   logic          armed, done_q;
   logic          s_hs, key_skip, to_hit, cap_fire, drained;

`ifdef AES_KEY_CACHE_EN
   assign key_skip = (wcnt == 2'd0) & ~s_new_key;
`else
   logic unused_new_key;
   assign unused_new_key = s_new_key;
   assign key_skip       = 1'b0;
`endif

   assign s_hs     = s_valid & s_ready;
   assign to_hit   = (TIMEOUT_CYC != 0) && (state == ST_WAIT)
                     && (tcnt >= TW'(TLIM));
   assign cap_fire = (state == ST_WAIT) & armed
                     & (ccnt == CDLY) & ~to_hit;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= ST_KEY;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      s_ready = 1'b0;
      core_ld = 1'b0;
      unique case (state)
         ST_KEY: begin
            s_ready = 1'b1;
            if (s_valid && (key_skip || wcnt == 2'd3))
               state_n = ST_TEXT;
         end
         ST_TEXT: begin
            s_ready = 1'b1;
            if (s_valid && wcnt == 2'd3)
               state_n = ST_LOAD;
         end
         ST_LOAD: begin
            core_ld = 1'b1;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (to_hit)
               state_n = ST_KEY;
            else if (cap_fire)
               state_n = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drained)
               state_n = ST_KEY;
         end
         default: state_n = ST_KEY;
      endcase
   end

   // tcnt holds the number of cycles elapsed since the ld cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         wcnt         <= '0;
         core_key     <= '0;
         core_text_in <= '0;
         done_q       <= 1'b0;
         armed        <= 1'b0;
         ccnt         <= '0;
         tcnt         <= '0;
         err_timeout  <= 1'b0;
      end else begin
         done_q <= core_done;
         if (s_hs) begin
            if (state == ST_KEY && !key_skip)
               core_key[aes_lsb(wcnt) +: AES_WORD_W] <= s_data;
            else
               core_text_in[aes_lsb(wcnt) +: AES_WORD_W] <= s_data;
            wcnt <= wcnt + 2'd1;
         end
         if (state == ST_LOAD) begin
            tcnt  <= TW'(1);
            armed <= 1'b0;
            ccnt  <= '0;
         end else if (state == ST_WAIT) begin
            tcnt <= tcnt + TW'(1);
            if (!armed && core_done && !done_q) begin
               armed <= 1'b1;
               ccnt  <= 3'd1;
            end else if (armed && ccnt != CDLY) begin
               ccnt <= ccnt + 3'd1;
            end
         end
         if (to_hit)
            err_timeout <= 1'b1;
      end
   end

   aes_word_unpack u_unpack (
      .clk     (clk),
      .reset   (reset),
      .load    (cap_fire),
      .blk     (core_text_out),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .drained (drained)
   );

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: directed stimulus with a behavioural core stand-in
// and a queue scoreboard checked by an independent output monitor.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;

   localparam int CD = 2;
   localparam int TO = 16;

   localparam logic [127:0] K1 = 128'hcafebabedeadbeefdeadbeef00000000;
   localparam logic [127:0] T1 = 128'hDBE17F0684546C5571D034433D9A94B7;
   localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] T2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] T3 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C3 = 128'h0123456789abcdeffedcba9876543210;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         s_new_key = 1'b0;
   logic         core_ld;
   logic [127:0] core_key, core_text_in;
   logic         core_done = 1'b0;
   logic [127:0] core_text_out = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [31:0]  m_data;
   logic         m_last;
   logic         err_timeout;

   int checks = 0;
   int errors = 0;
   int out_cnt = 0;
   int bp_left = 0;
   bit sready_chk = 1'b0;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   aes_stream_ctrl #(
      .CAPTURE_DLY (CD),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_new_key     (s_new_key),
      .core_ld       (core_ld),
      .core_key      (core_key),
      .core_text_in  (core_text_in),
      .core_done     (core_done),
      .core_text_out (core_text_out),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .err_timeout   (err_timeout)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_s_ready"}, s_ready, 1);
      chk({tag, "_core_ld"}, core_ld, 0);
      chk({tag, "_core_key"}, core_key, 0);
      chk({tag, "_core_text_in"}, core_text_in, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   task automatic send_words(input logic [127:0] k, input logic [127:0] t,
                             input bit with_key, input bit nk, input int n);
      logic [127:0] src;
      int wi, g;
      for (int i = 0; i < n; i++) begin
         src = (with_key && i < 4) ? k : t;
         wi  = i % 4;
         @(posedge clk); #1;
         s_valid   = 1'b1;
         s_data    = src[127-32*wi -: 32];
         s_new_key = (i == 0) ? nk : ~nk;
         g = 0;
         @(negedge clk);
         while (!s_ready && g < 64) begin
            @(negedge clk);
            g++;
         end
         if (!s_ready)
            chk("s_ready_wait", s_ready, 1);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic core_respond(input logic [127:0] ek, input logic [127:0] et,
                               input logic [127:0] ct, input int lat,
                               input bit keep_high);
      exp_t e;
      @(negedge clk);
      chk("ld_after_last_word", core_ld, 1);
      chk("core_key", core_key, ek);
      chk("core_text_in", core_text_in, et);
      @(negedge clk);
      chk("ld_single_cycle", core_ld, 0);
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #1;
         core_text_out = ~ct;
         @(negedge clk);
         chk("no_early_valid", m_valid, 0);
      end
      @(posedge clk); #1;
      core_done = 1'b0;
      for (int w = 0; w < 4; w++) begin
         e.last = (w == 3);
         e.data = ct[127-32*w -: 32];
         sb.push_back(e);
      end
      for (int k = 0; k <= CD + 1; k++) begin
         @(posedge clk); #1;
         core_done     = 1'b1;
         core_text_out = (k == CD) ? ct : ~ct;
         @(negedge clk);
         chk("valid_timing", m_valid, k == CD + 1);
      end
      if (!keep_high) begin
         @(posedge clk); #1;
         core_done = 1'b0;
      end
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain_done", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (bp_left > 0 && m_valid && (out_cnt % 4) == 1) begin
         m_ready = 1'b0;
         bp_left--;
      end else begin
         m_ready = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (sready_chk) begin
         sready_chk = 1'b0;
         chk("s_ready_after_last", s_ready, 1);
      end
      if (reset && m_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got m_data %h with nothing expected",
                     m_data);
         end else begin
            checks++;
            if (m_data !== sb[0].data || m_last !== sb[0].last) begin
               errors++;
               $display("FAIL out_word%0d: got %h/%b expected %h/%b",
                        out_cnt % 4, m_data, m_last, sb[0].data, sb[0].last);
            end
            if (m_ready) begin
               if (sb[0].last)
                  sready_chk = 1'b1;
               void'(sb.pop_front());
               out_cnt++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      send_words(K1, T1, 1, 1, 8);
      core_respond(K1, T1, C1, 1, 0);
      drain();

      bp_left = 5;
      send_words(K2, T2, 1, 1, 8);
      core_respond(K2, T2, C2, 4, 1);
      drain();
      chk("bp_applied", bp_left, 0);

      send_words(K3, T3, 1, 1, 8);
      core_respond(K3, T3, C3, 6, 0);
      drain();

      send_words(K1, T3, 1, 1, 8);
      @(negedge clk);
      chk("to_ld", core_ld, 1);
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         if (c == TO - 1)
            chk("to_not_early", err_timeout, 0);
         if (c == TO) begin
            chk("to_flag", err_timeout, 1);
            chk("to_s_ready", s_ready, 1);
            chk("to_no_valid", m_valid, 0);
         end
      end

      send_words(K2, T1, 1, 1, 7);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset("mid_reset");
      @(posedge clk); #1;
      reset = 1'b1;
      send_words(K1, T2, 1, 1, 8);
      core_respond(K1, T2, C1, 2, 0);
      drain();

`ifdef AES_KEY_CACHE_EN
      send_words('0, T3, 0, 0, 4);
      core_respond(K1, T3, C2, 1, 0);
      drain();
      send_words(K3, T1, 1, 1, 8);
      core_respond(K3, T1, C3, 1, 0);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Streaming front/back-end for the AES cipher core. It assembles 32-bit input words into a 128-bit key and plaintext, pulses the core's `ld`, and waits for `done` rising. It then captures `text_out` after a fixed settle delay and streams the ciphertext back out as four 32-bit words. It sits between the system word bus and `aes_cipher_top`, in the core's `clk` domain.

## Interface
Parameters:
- CAPTURE_DLY, 2, `clk` cycles between the detected `done` rising edge and sampling `core_text_out` (1..7).
- TIMEOUT_CYC, 1024, maximum cycles to wait for `done` after `ld`; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the same clock that drives the core's `clk`.
- reset  in  1  reset, synchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when `s_valid & s_ready`.
- s_data  in  32  input word.
- s_new_key  in  1  sampled on the first word of a block; used only with AES_KEY_CACHE_EN.
- core_ld  out  1  one-cycle load pulse to the core.
- core_key  out  128  key register.
- core_text_in  out  128  plaintext register.
- core_done  in  1  core done; synchronous to `clk`.
- core_text_out  in  128  core ciphertext.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  32  ciphertext word.
- m_last  out  1  high on output word 3.
- err_timeout  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Word order: word 0 carries bits [127:96], and word 3 carries bits [31:0]. This applies to key, text and output.
- Block format without cache: 4 key words, then 4 text words.
- States:
  - KEY: `s_ready`=1. Each accepted word goes into `core_key`. The 2-bit word counter wraps 3→0, then the state moves to TEXT.
  - TEXT: `s_ready`=1. Words go into `core_text_in`. After word 3, the state moves to LOAD.
  - LOAD: `s_ready`=0. Assert `core_ld` for exactly one cycle, clear the timeout counter, then move to WAIT.
  - WAIT: detect the rising edge of `core_done`, comparing against a registered previous value. Then count CAPTURE_DLY cycles and latch `core_text_out` into the output buffer. Move to DRAIN.
  - Timeout in WAIT: if the counter reaches TIMEOUT_CYC first, set `err_timeout`, leave the output buffer unchanged, and return to KEY without producing output.
  - DRAIN: `m_valid`=1 and `m_data` = buffer word n. Advance n on `m_valid & m_ready`. After word 3 is accepted (`m_last`=1), return to the block-start state.
- `core_key` and `core_text_in` hold stable from LOAD until the next write.
- `core_done` already high when entering WAIT is not a rising edge. The controller waits for a fresh 0→1 transition.
- `s_valid` outside KEY/TEXT is ignored; `s_ready`=0 there.
- The block-start state is KEY, or the cache decision described under Configuration.

## Timing
- Reset values:
  - `s_ready`=1 (state KEY), `core_ld`=0, `core_key`=0, `core_text_in`=0.
  - `m_valid`=0, `m_data`=0, `m_last`=0, `err_timeout`=0.
  - Word counters = 0.
- The first accepted word lands in its register on the following edge.
- `core_ld` rises one cycle after the TEXT word-3 handshake.
- `m_valid` rises at CAPTURE_DLY+1 cycles after `core_done` rises. The extra cycle is for edge detection.
- Back-pressure: `m_data` and `m_last` hold while `m_valid & !m_ready`.
- After the last output handshake, `s_ready` is 1 on the next cycle.
- Reset mid-operation discards any partial block, output buffer contents and the key.

## Configuration
- AES_KEY_CACHE_EN defined:
  - At block start, `s_new_key` is sampled with the first word.
  - If it is 1, the block follows the 8-word format and the key is reloaded.
  - If it is 0, that word is text word 0; the block is 4 text words and the previous `core_key` is reused.
  - The key is retained across blocks and after a timeout.
- AES_KEY_CACHE_EN undefined:
  - `s_new_key` is ignored.
  - Every block is 8 words.

## Structure
- Shared package `aes_pkg` holds:
  - The state enum (KEY, TEXT, LOAD, WAIT, DRAIN).
  - Localparams AES_BLK_W=128, AES_WORD_W=32, AES_WORDS=4.
  - The word-index-to-slice helper.
- One sub-module `aes_word_unpack`: the 4×32 output buffer with index counter, `m_valid`/`m_ready` handling and `m_last`.

## Test plan
- Stimulus: key `cafebabedeadbeefdeadbeef00000000` and text `DBE17F0684546C5571D034433D9A94B7` as 8 words. Required: `core_key` and `core_text_in` match exactly, a single-cycle `core_ld` pulse, and 4 output words equal to the core's `text_out` captured CAPTURE_DLY cycles after `done` rises.
- Stimulus: `m_ready` held low for 5 cycles on word 1. Required: `m_data` stable, no word skipped or duplicated, `m_last` only on word 3.
- Stimulus: `core_done` held low with TIMEOUT_CYC=16. Required: `err_timeout`=1 exactly 16 cycles after `ld`, no `m_valid`, `s_ready`=1 next cycle.
- Stimulus (AES_KEY_CACHE_EN): a second block with `s_new_key`=0 and 4 text words. Required: `core_key` is unchanged and `ld` pulses after 4 words. A third block with `s_new_key`=1 reloads the key.
- Stimulus: `reset` driven low after text word 2. Required: all outputs at reset values next cycle, and a full new block processes correctly.
- Stimulus: `core_done` left high from the previous block at LOAD. Required: no premature capture; capture only on the fresh rising edge.
